// File: rtl/pong_game_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_ctrl_pkg
// Description : Shared Pong playfield geometry, FSM state encoding and
//               winner codes.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_game_ctrl_pkg;

    localparam logic [9:0] LEFT_GAME_BOUND  = 10'd10;
    localparam logic [9:0] RIGHT_GAME_BOUND = 10'd630;
    localparam logic [9:0] BALL_RADIUS      = 10'd8;
    localparam logic [9:0] PADDLE_WIDTH     = 10'd10;
    localparam logic [9:0] PADDLE_HEIGHT    = 10'd80;
    localparam logic [9:0] V_OFFSET         = 10'd30;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [1:0] WINNER_NONE = 2'd0;
    localparam logic [1:0] WINNER_P1   = 2'd1;
    localparam logic [1:0] WINNER_P2   = 2'd2;

endpackage : pong_game_ctrl_pkg
`default_nettype wire

// File: rtl/pong_game_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_ctrl_tick_gen
// Description : Free-running TICK_DIV counter with a registered one-cycle
//               game tick, shared by every game-rate block.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_game_ctrl_tick_gen #(
    parameter int unsigned TICK_DIV = 1048576
) (
    input  logic clk,
    input  logic rst,
    output logic game_tick
);

    localparam int unsigned          c_cnt_w   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0]   c_cnt_max = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] count_q;
    logic [c_cnt_w-1:0] count_d;
    logic               tick_q;
    logic               tick_d;

    always_comb begin
        count_d = count_q + 1'b1;
        tick_d  = 1'b0;
        if (count_q == c_cnt_max) begin
            count_d = '0;
            tick_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign game_tick = tick_q;

endmodule : pong_game_ctrl_tick_gen
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_ctrl
// Description : Pong game sequencer - game tick, miss detection, scoring and
//               the IDLE/SERVE/PLAY/POINT/OVER flow.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_game_ctrl
    import pong_game_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 1048576,
    parameter int unsigned SERVE_TICKS = 60,
    parameter int unsigned POINT_TICKS = 90,
    parameter int unsigned WIN_SCORE   = 7,
    parameter logic [9:0]  LEFT_BOUND  = LEFT_GAME_BOUND,
    parameter logic [9:0]  RIGHT_BOUND = RIGHT_GAME_BOUND
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic [9:0] ball_Pos_H,
    output logic       game_tick,
    output logic       move_en,
    output logic       ball_load,
    output logic       serve_dir,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam int unsigned        c_tmr_max  = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int unsigned        c_tmr_w    = $clog2(c_tmr_max + 1);
    localparam logic [c_tmr_w-1:0] c_serve_ld = c_tmr_w'(SERVE_TICKS);
    localparam logic [c_tmr_w-1:0] c_point_ld = c_tmr_w'(POINT_TICKS);
    localparam logic [c_tmr_w-1:0] c_tmr_one  = c_tmr_w'(1);
    localparam logic [3:0]         c_win      = 4'(WIN_SCORE);

    state_t               state_q,     state_d;
    logic [c_tmr_w-1:0]   timer_q,     timer_d;
    logic [3:0]           score_p1_q,  score_p1_d;
    logic [3:0]           score_p2_q,  score_p2_d;
    logic [1:0]           winner_q,    winner_d;
    logic                 serve_dir_q, serve_dir_d;
    logic                 ball_load_q, ball_load_d;
    logic                 start_prev_q;

    logic                 w_start_edge;
    logic                 w_active;
    logic                 w_miss_left;
    logic                 w_miss_right;
    logic [3:0]           w_p1_inc;
    logic [3:0]           w_p2_inc;

    pong_game_ctrl_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .game_tick (game_tick)
    );

    assign w_start_edge = start & ~start_prev_q;
    assign w_active     = game_tick & ~pause;
    assign w_miss_left  = (ball_Pos_H <= LEFT_BOUND);
    assign w_miss_right = (ball_Pos_H >= RIGHT_BOUND);
    assign w_p1_inc     = score_p1_q + 4'd1;
    assign w_p2_inc     = score_p2_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        winner_d    = winner_q;
        serve_dir_d = serve_dir_q;
        ball_load_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (w_start_edge) begin
                    state_d     = ST_SERVE;
                    timer_d     = c_serve_ld;
                    ball_load_d = 1'b1;
                end
            end

            ST_SERVE: begin
                if (w_active) begin
                    timer_d = timer_q - c_tmr_one;
                    if (timer_q == c_tmr_one) begin
                        state_d = ST_PLAY;
                    end
                end
            end

            ST_PLAY: begin
                // Left miss takes priority when both bounds are hit at once.
                if (w_active && w_miss_left) begin
                    serve_dir_d = 1'b0;
                    if (score_p2_q < c_win) begin
                        score_p2_d = w_p2_inc;
                    end
                    if (w_p2_inc == c_win) begin
                        state_d  = ST_OVER;
                        winner_d = WINNER_P2;
                    end else begin
                        state_d = ST_POINT;
                        timer_d = c_point_ld;
                    end
                end else if (w_active && w_miss_right) begin
                    serve_dir_d = 1'b1;
                    if (score_p1_q < c_win) begin
                        score_p1_d = w_p1_inc;
                    end
                    if (w_p1_inc == c_win) begin
                        state_d  = ST_OVER;
                        winner_d = WINNER_P1;
                    end else begin
                        state_d = ST_POINT;
                        timer_d = c_point_ld;
                    end
                end
            end

            ST_POINT: begin
                if (w_active) begin
                    timer_d = timer_q - c_tmr_one;
                    if (timer_q == c_tmr_one) begin
                        state_d     = ST_SERVE;
                        timer_d     = c_serve_ld;
                        ball_load_d = 1'b1;
                    end
                end
            end

            ST_OVER: begin
                if (w_start_edge) begin
                    score_p1_d  = 4'd0;
                    score_p2_d  = 4'd0;
                    winner_d    = WINNER_NONE;
                    serve_dir_d = 1'b1;
                    state_d     = ST_SERVE;
                    timer_d     = c_serve_ld;
                    ball_load_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // start_prev resets high so a button held through reset needs a new press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            score_p1_q   <= 4'd0;
            score_p2_q   <= 4'd0;
            winner_q     <= WINNER_NONE;
            serve_dir_q  <= 1'b1;
            ball_load_q  <= 1'b0;
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            score_p1_q   <= score_p1_d;
            score_p2_q   <= score_p2_d;
            winner_q     <= winner_d;
            serve_dir_q  <= serve_dir_d;
            ball_load_q  <= ball_load_d;
            start_prev_q <= start;
        end
    end

    assign move_en   = (state_q == ST_PLAY) & ~pause;
    assign ball_load = ball_load_q;
    assign serve_dir = serve_dir_q;
    assign score_p1  = score_p1_q;
    assign score_p2  = score_p2_q;
    assign winner    = winner_q;
    assign state     = state_q;

endmodule : pong_game_ctrl
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_game_ctrl
// Description : Directed scoreboard bench for pong_game_ctrl (small tick
//               divider, short countdowns, first to three wins).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

    localparam int unsigned TICK_DIV    = 4;
    localparam int unsigned SERVE_TICKS = 3;
    localparam int unsigned POINT_TICKS = 2;
    localparam int unsigned WIN_SCORE   = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pause;
    logic [9:0] ball_Pos_H;
    logic       game_tick;
    logic       move_en;
    logic       ball_load;
    logic       serve_dir;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic [1:0] winner;
    logic [2:0] state;

    typedef struct {
        string tag;
        int    st;
        int    p1;
        int    p2;
        int    win;
        int    bl;
        int    me;
        int    sd;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    pong_game_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .SERVE_TICKS (SERVE_TICKS),
        .POINT_TICKS (POINT_TICKS),
        .WIN_SCORE   (WIN_SCORE),
        .LEFT_BOUND  (10'd10),
        .RIGHT_BOUND (10'd630)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .ball_Pos_H (ball_Pos_H),
        .game_tick  (game_tick),
        .move_en    (move_en),
        .ball_load  (ball_load),
        .serve_dir  (serve_dir),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .winner     (winner),
        .state      (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic push(input string tag, input int st, input int p1, input int p2,
                        input int win, input int bl, input int me, input int sd);
        exp_t e;
        e.tag = tag; e.st = st; e.p1 = p1; e.p2 = p2;
        e.win = win; e.bl = bl; e.me = me; e.sd = sd;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".state"},     32'(state),     e.st);
            chk({e.tag, ".score_p1"},  32'(score_p1),  e.p1);
            chk({e.tag, ".score_p2"},  32'(score_p2),  e.p2);
            chk({e.tag, ".winner"},    32'(winner),    e.win);
            chk({e.tag, ".ball_load"}, 32'(ball_load), e.bl);
            chk({e.tag, ".move_en"},   32'(move_en),   e.me);
            chk({e.tag, ".serve_dir"}, 32'(serve_dir), e.sd);
        end
    endtask

    // Advance until a game tick is on the output, then past the edge that consumes it.
    task automatic next_tick();
        int k;
        k = 0;
        while (game_tick !== 1'b1 && k < 2 * TICK_DIV) begin
            step(1);
            k++;
        end
        chk("tick_timeout", 32'(game_tick), 32'd1);
        step(1);
    endtask

    task automatic tick_expect(input string tag, input int st, input int p1, input int p2,
                               input int win, input int bl, input int me, input int sd);
        push(tag, st, p1, p2, win, bl, me, sd);
        next_tick();
        pop_check();
    endtask

    // POINT countdown, re-serve with a one-clock ball_load, then back into PLAY.
    task automatic recycle(input int p1, input int p2, input int sd);
        tick_expect("point_wait",  3, p1, p2, 0, 0, 0, sd);
        tick_expect("reserve",     1, p1, p2, 0, 1, 0, sd);
        push("reserve_bl_low", 1, p1, p2, 0, 0, 0, sd);
        step(1);
        pop_check();
        tick_expect("serve_t1",    1, p1, p2, 0, 0, 0, sd);
        tick_expect("serve_t2",    1, p1, p2, 0, 0, 0, sd);
        tick_expect("serve_play",  2, p1, p2, 0, 0, 1, sd);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b1;
        pause      = 1'b0;
        ball_Pos_H = 10'd320;
        repeat (3) @(posedge clk);
        #1;
        push("reset", 0, 0, 0, 0, 0, 0, 1);
        pop_check();
        chk("reset.game_tick", 32'(game_tick), 32'd0);

        // Idle with start held through reset: ticks every 4th clock, no serve.
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            push("idle_held", 0, 0, 0, 0, 0, 0, 1);
            step(1);
            chk("idle.game_tick", 32'(game_tick), (cyc % 4 == 0) ? 32'd1 : 32'd0);
            pop_check();
        end

        start = 1'b0;
        push("start_low", 0, 0, 0, 0, 0, 0, 1);
        step(1);
        pop_check();
        start = 1'b1;
        push("serve_entry", 1, 0, 0, 0, 1, 0, 1);
        step(1);
        pop_check();
        push("serve_bl_low", 1, 0, 0, 0, 0, 0, 1);
        step(1);
        pop_check();
        tick_expect("serve_t1",   1, 0, 0, 0, 0, 0, 1);
        tick_expect("serve_t2",   1, 0, 0, 0, 0, 0, 1);
        tick_expect("serve_play", 2, 0, 0, 0, 0, 1, 1);

        // Left miss: P2 scores, serve toward P1.
        ball_Pos_H = 10'd5;
        tick_expect("left_miss", 3, 0, 1, 0, 0, 0, 0);
        ball_Pos_H = 10'd320;
        recycle(0, 1, 0);

        // Pause freezes play and miss detection.
        pause      = 1'b1;
        ball_Pos_H = 10'd5;
        push("paused", 2, 0, 1, 0, 0, 0, 0);
        step(1);
        pop_check();
        for (int i = 0; i < 5; i++) begin
            tick_expect("paused_tick", 2, 0, 1, 0, 0, 0, 0);
        end
        pause = 1'b0;
        tick_expect("unpause_miss", 3, 0, 2, 0, 0, 0, 0);
        ball_Pos_H = 10'd320;
        recycle(0, 2, 0);

        // Right misses until P1 reaches the winning score.
        ball_Pos_H = 10'd635;
        tick_expect("right_miss1", 3, 1, 2, 0, 0, 0, 1);
        ball_Pos_H = 10'd320;
        recycle(1, 2, 1);
        ball_Pos_H = 10'd635;
        tick_expect("right_miss2", 3, 2, 2, 0, 0, 0, 1);
        ball_Pos_H = 10'd320;
        recycle(2, 2, 1);
        ball_Pos_H = 10'd635;
        tick_expect("p1_wins",   4, 3, 2, 1, 0, 0, 1);
        tick_expect("over_hold", 4, 3, 2, 1, 0, 0, 1);
        tick_expect("over_hold", 4, 3, 2, 1, 0, 0, 1);

        start = 1'b0;
        push("over_start_low", 4, 3, 2, 1, 0, 0, 1);
        step(1);
        pop_check();
        start = 1'b1;
        push("restart", 1, 0, 0, 0, 1, 0, 1);
        step(1);
        pop_check();
        ball_Pos_H = 10'd320;
        tick_expect("serve_t1",   1, 0, 0, 0, 0, 0, 1);
        tick_expect("serve_t2",   1, 0, 0, 0, 0, 0, 1);
        tick_expect("serve_play", 2, 0, 0, 0, 0, 1, 1);

        // Build a 2:1 score, then reset in the middle of POINT.
        ball_Pos_H = 10'd635;
        tick_expect("r_miss_a", 3, 1, 0, 0, 0, 0, 1);
        ball_Pos_H = 10'd320;
        recycle(1, 0, 1);
        ball_Pos_H = 10'd635;
        tick_expect("r_miss_b", 3, 2, 0, 0, 0, 0, 1);
        ball_Pos_H = 10'd320;
        recycle(2, 0, 1);
        ball_Pos_H = 10'd5;
        tick_expect("l_miss_c", 3, 2, 1, 0, 0, 0, 0);
        ball_Pos_H = 10'd320;
        #2;
        rst = 1'b1;
        #1;
        push("async_reset", 0, 0, 0, 0, 0, 0, 1);
        pop_check();
        chk("async_reset.game_tick", 32'(game_tick), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            push("post_reset", 0, 0, 0, 0, 0, 0, 1);
            step(1);
            chk("post_reset.game_tick", 32'(game_tick), (cyc == 4) ? 32'd1 : 32'd0);
            pop_check();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_pong_game_ctrl
`default_nettype wire
